if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: IF_STAGE

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-high reset: clk  input  1  rising-edge clock; rst  input  1  asynchronous, active-high reset.
REQ-002 freeze  input  1  hazard stall request from the hazard unit.
REQ-003 branch_taken  input  1  branch resolved taken in EXE.
REQ-004 branch_addr  input  32  branch target byte address.
REQ-005 flush  input  1  squash the instruction being latched into IF/ID.
REQ-006 imem_addr  output  32  byte address to the instruction memory, equal to the PC register.
REQ-007 imem_instr  input  32  instruction word returned combinationally by the instruction memory for imem_addr.
REQ-008 if_id_pc  output  32  PC+4 of the instruction held in IF/ID.
REQ-009 if_id_instr  output  32  instruction held in IF/ID.
REQ-010 if_id_valid  output  1  IF/ID holds a real instruction; 0 means bubble.
REQ-011 stall_count  output  16  saturating count of frozen fetch cycles.

Function
REQ-012 The PC register SHALL drive imem_addr combinationally, with no added latency.
REQ-013 PC[1:0] SHALL always be 0; branch_addr[1:0] is ignored on load.
REQ-014 On each rising edge, the PC SHALL update in this priority order:
- branch_taken: PC <= {branch_addr[31:2],2'b00}
- else freeze: PC holds
- else: PC <= PC+4, modulo 2^32 (0xFFFFFFFC wraps to 0x00000000)
REQ-015 On each rising edge, the IF/ID register SHALL update in this priority order:
- branch_taken or flush: if_id_instr <= 0, if_id_pc <= 0, if_id_valid <= 0
- else freeze: all IF/ID fields hold
- else: if_id_instr <= imem_instr, if_id_pc <= PC+4, if_id_valid <= 1
REQ-016 Fetch latency: the instruction at address A SHALL appear on if_id_instr exactly one edge after imem_addr = A, provided no freeze, flush or branch occurs at that edge.
REQ-017 branch_taken SHALL override freeze in the same cycle: the PC loads the target and IF/ID becomes a bubble.
REQ-018 flush without branch_taken SHALL still advance the PC normally, or hold it if freeze is also high; only IF/ID is squashed.
REQ-019 stall_count SHALL increment by 1 on each edge where freeze=1 and branch_taken=0.
REQ-020 stall_count SHALL saturate at 0xFFFF and never wrap.
REQ-021 Every output SHALL be a registered value or a direct register copy, except that imem_instr is sampled only at the clock edge.
REQ-022 The block SHALL contain no other state; IF/ID fields SHALL change only at clock edges or on reset.

Reset
REQ-023 Asserting rst SHALL immediately clear, independent of clk: PC=0, imem_addr=0, if_id_pc=0, if_id_instr=0, if_id_valid=0, stall_count=0.
REQ-024 Reset asserted mid-operation, including during freeze or branch, SHALL abandon all in-flight state.
REQ-025 On the first rising edge after rst deasserts, with no freeze, the block SHALL latch the word at address 0 into IF/ID and set PC=4.
REQ-026 While rst is high, all clock edges SHALL be ignored.

Verification
REQ-027 Sequential fetch: memory word n = n. Release reset, run 4 edges -> imem_addr 0,4,8,12,16; if_id_instr 0,1,2,3 with if_id_pc 4,8,12,16; if_id_valid=1 from edge 1.
REQ-028 Freeze: with PC=8, hold freeze=1 for 3 edges -> PC stays 8; IF/ID holds word 1 / pc 8; stall_count goes 0 to 3. After release -> next edge latches word 2, PC=12.
REQ-029 Branch over freeze: with PC=20, freeze=1, branch_taken=1, branch_addr=0x00000103 -> after the edge PC=0x100, if_id_valid=0, if_id_instr=0, stall_count unchanged.
REQ-030 Flush only: with PC=12, flush=1 -> after the edge PC=16, if_id_valid=0, if_id_instr=0; next edge latches the word at 16 with valid=1.
REQ-031 Wrap and saturation: branch to 0xFFFFFFFC, then one normal edge -> PC=0, if_id_pc=0; preload stall_count near 0xFFFF via a long freeze -> it stays at 0xFFFF.
REQ-032 Async reset: assert rst between clock edges while freeze=1 and PC=0x40 -> all outputs become 0 before the next edge and stay 0 while rst is high.

Source files
------------

// File: rtl/if_stage.sv
// ============================================================================
// Module   : if_stage
// Purpose  : Instruction fetch stage: PC register plus IF/ID pipeline register
//            with freeze, branch redirect, flush squash and a stall counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module if_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    input  logic        flush,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid,
    output logic [15:0] stall_count
);

    localparam logic [15:0] c_stall_max = 16'hFFFF;

    logic [31:0] r_pc;
    logic [31:0] r_if_id_pc;
    logic [31:0] r_if_id_instr;
    logic        r_if_id_valid;
    logic [15:0] r_stall_count;
    logic [31:0] w_pc_plus4;

    assign w_pc_plus4 = r_pc + 32'd4;

    // Branch redirect wins over a hazard freeze.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= 32'd0;
        end else if (branch_taken) begin
            r_pc <= {branch_addr[31:2], 2'b00};
        end else if (!freeze) begin
            r_pc <= w_pc_plus4;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_if_id_pc    <= 32'd0;
            r_if_id_instr <= 32'd0;
            r_if_id_valid <= 1'b0;
        end else if (branch_taken || flush) begin
            r_if_id_pc    <= 32'd0;
            r_if_id_instr <= 32'd0;
            r_if_id_valid <= 1'b0;
        end else if (!freeze) begin
            r_if_id_pc    <= w_pc_plus4;
            r_if_id_instr <= imem_instr;
            r_if_id_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_count <= 16'd0;
        end else if (freeze && !branch_taken && (r_stall_count != c_stall_max)) begin
            r_stall_count <= r_stall_count + 16'd1;
        end
    end

    assign imem_addr   = r_pc;
    assign if_id_pc    = r_if_id_pc;
    assign if_id_instr = r_if_id_instr;
    assign if_id_valid = r_if_id_valid;
    assign stall_count = r_stall_count;

endmodule

`default_nettype wire

// File: tb/tb_if_stage.sv
// ============================================================================
// Module   : tb_if_stage
// Purpose  : Self-checking bench for if_stage against a behavioural fetch model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_if_stage;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic        flush;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic [15:0] stall_count;

    logic [31:0] seed;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state.
    logic [31:0] m_pc;
    logic [31:0] m_pcid;
    logic [31:0] m_instr;
    logic        m_valid;
    int          m_stall;

    if_stage dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .flush        (flush),
        .imem_addr    (imem_addr),
        .imem_instr   (imem_instr),
        .if_id_pc     (if_id_pc),
        .if_id_instr  (if_id_instr),
        .if_id_valid  (if_id_valid),
        .stall_count  (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: word n holds n, optionally scrambled by seed.
    always_comb imem_instr = (imem_addr >> 2) ^ seed;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("imem_addr",   imem_addr,           m_pc);
        check("if_id_pc",    if_id_pc,            m_pcid);
        check("if_id_instr", if_id_instr,         m_instr);
        check("if_id_valid", {31'd0, if_id_valid}, {31'd0, m_valid});
        check("stall_count", {16'd0, stall_count}, m_stall[31:0]);
    end

    task automatic model_reset();
        m_pc = 0; m_pcid = 0; m_instr = 0; m_valid = 0; m_stall = 0;
    endtask

    // Drive one cycle's inputs, advance the model at the edge, return at the next negedge.
    task automatic tick(input logic f, input logic b, input logic fl, input logic [31:0] ba);
        logic [31:0] fetched;
        freeze = f; branch_taken = b; flush = fl; branch_addr = ba;
        @(posedge clk);
        fetched = (m_pc >> 2) ^ seed;
        if (b || fl) begin
            m_pcid = 0; m_instr = 0; m_valid = 0;
        end else if (!f) begin
            m_pcid = m_pc + 4; m_instr = fetched; m_valid = 1;
        end
        if (f && !b) m_stall = (m_stall + 1 > 65535) ? 65535 : m_stall + 1;
        if (b)       m_pc = ba & 32'hFFFF_FFFC;
        else if (!f) m_pc = m_pc + 4;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; freeze = 0; branch_taken = 0; flush = 0; branch_addr = 0; seed = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset imem_addr", imem_addr, 32'd0);
        check("reset valid", {31'd0, if_id_valid}, 32'd0);
        rst = 1'b0;

        // Sequential fetch from address 0.
        for (int k = 1; k <= 4; k++) begin
            tick(0, 0, 0, 0);
            check("seq imem_addr", imem_addr, 32'(4 * k));
            check("seq instr", if_id_instr, 32'(k - 1));
            check("seq if_id_pc", if_id_pc, 32'(4 * k));
            check("seq valid", {31'd0, if_id_valid}, 32'd1);
        end

        // Set PC=8 holding word 1, then freeze for three edges.
        tick(0, 1, 0, 32'd4);
        tick(0, 0, 0, 0);
        check("pre-freeze pc", imem_addr, 32'd8);
        repeat (3) tick(1, 0, 0, 0);
        check("freeze pc", imem_addr, 32'd8);
        check("freeze instr", if_id_instr, 32'd1);
        check("freeze if_id_pc", if_id_pc, 32'd8);
        check("freeze stall", {16'd0, stall_count}, 32'd3);
        tick(0, 0, 0, 0);
        check("unfreeze instr", if_id_instr, 32'd2);
        check("unfreeze pc", imem_addr, 32'd12);

        // Flush only.
        tick(0, 0, 1, 0);
        check("flush pc", imem_addr, 32'd16);
        check("flush valid", {31'd0, if_id_valid}, 32'd0);
        check("flush instr", if_id_instr, 32'd0);
        tick(0, 0, 0, 0);
        check("post-flush instr", if_id_instr, 32'd4);
        check("post-flush valid", {31'd0, if_id_valid}, 32'd1);

        // Branch over freeze with misaligned target.
        check("pre-branch pc", imem_addr, 32'd20);
        tick(1, 1, 0, 32'h0000_0103);
        check("branch pc", imem_addr, 32'h0000_0100);
        check("branch valid", {31'd0, if_id_valid}, 32'd0);
        check("branch instr", if_id_instr, 32'd0);
        check("branch stall", {16'd0, stall_count}, 32'd3);

        // PC wrap.
        tick(0, 1, 0, 32'hFFFF_FFFF);
        check("wrap pre pc", imem_addr, 32'hFFFF_FFFC);
        tick(0, 0, 0, 0);
        check("wrap pc", imem_addr, 32'd0);
        check("wrap if_id_pc", if_id_pc, 32'd0);
        check("wrap instr", if_id_instr, 32'h3FFF_FFFF);

        // Randomized traffic with scrambled memory contents.
        seed = $urandom;
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] ba;
            ba = $urandom;
            tick(($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 7) == 0), ba);
        end

        // Long freeze to drive the stall counter into saturation.
        for (int i = 0; i < 65600; i++) tick(1, 0, 0, 0);
        check("stall saturated", {16'd0, stall_count}, 32'h0000_FFFF);
        tick(1, 0, 0, 0);
        check("stall held", {16'd0, stall_count}, 32'h0000_FFFF);

        // Async reset during freeze at PC=0x40.
        seed = 0;
        tick(0, 1, 0, 32'h0000_0040);
        tick(1, 0, 0, 0);
        check("pre-reset pc", imem_addr, 32'h0000_0040);
        @(posedge clk);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check("async imem_addr", imem_addr, 32'd0);
        check("async if_id_pc", if_id_pc, 32'd0);
        check("async valid", {31'd0, if_id_valid}, 32'd0);
        check("async stall", {16'd0, stall_count}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        tick(0, 0, 0, 0);
        check("post-reset pc", imem_addr, 32'd4);
        check("post-reset valid", {31'd0, if_id_valid}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
